stage_fetch_q: RTL and testbench
================================

Name: stage_fetch_q

Overview:
Parametrised next-generation fetch stage. It owns the PC and issues requests to instruction memory over a request/grant + response-valid handshake, with several requests allowed in flight. It follows BTB predictions and buffers returned instructions in a fetch queue feeding decode through a valid/ready interface. A redirect from EX flushes the queue and squashes every in-flight response.

Parameters:
XLEN, 32, address/instruction width
QDEPTH, 4, fetch queue entries (power of 2, >=2)
MAX_OUT, 2, max outstanding imem requests (>=1)
RESET_PC, 32'h00000060, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
redirect_valid  in  1  EX mispredict/jump resolution
redirect_pc  in  XLEN  corrected PC
btb_hit  in  1  BTB hit for current pc_out (combinational lookup)
btb_target  in  XLEN  predicted target
pc_out  out  XLEN  current fetch PC (BTB lookup index)
imem_req  out  1  request valid
imem_addr  out  XLEN  request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid (in order, >=1 cycle after grant)
imem_rdata  in  XLEN  instruction word
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head instruction
out_instr  out  XLEN  head instruction
out_pred_taken  out  1  head was fetched with btb_hit
out_pred_pc  out  XLEN  next PC chosen at fetch (btb_target or pc+4)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, queue empty, tag FIFO empty, outstanding=0; imem_req=0, out_valid=0, out_* = 0.
- imem_addr = pc_out combinationally. imem_req=1 iff redirect_valid=0, outstanding<MAX_OUT, and queue_count+live_outstanding<QDEPTH (credit rule: queue can never overflow).
- Request not committed until imem_req&&imem_gnt. imem_addr may change before a grant; the memory must sample on grant only.
- Grant: pc <= btb_hit ? btb_target : pc+4 (mod 2^XLEN wrap). Push tag {pc, btb_hit, next_pc, live=1} into a MAX_OUT-deep tag FIFO. outstanding++.
- imem_rvalid: pop the tag FIFO and decrement outstanding. If the tag is live, push {pc, rdata, pred} into the queue; otherwise drop. rvalid with an empty tag FIFO is a protocol error (assertion).
- Grant and rvalid in the same cycle: outstanding unchanged; both FIFO operations occur.
- Redirect (top priority):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Queue flushed; all tag live bits cleared; outstanding kept, since stale responses still return.
  - An rvalid in the redirect cycle is dropped.
  - imem_req forced 0 that cycle. The first post-redirect request is issued the next cycle.
- Output: out_valid = queue non-empty; out_* = head fields. Pop on out_valid&&out_ready. Push and pop in one cycle allowed at any occupancy. A pop in a redirect cycle is superseded by the flush.
- Minimum latency: grant at cycle T, rvalid at T+1, out_valid at T+2. Sustained 1 instr/cycle with MAX_OUT>=2 and 1-cycle memory.
- Reset mid-operation: all state cleared immediately. Responses to pre-reset requests are not tracked; memory is reset together with the block.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_squash_cnt[31:0] (stale responses dropped) and perf_stall_cnt[31:0] (cycles with redirect_valid=0 and imem_req blocked by credit or MAX_OUT limit). Both saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, 1-cycle memory, out_ready=1, no BTB hits -> imem_addr 0x60,0x64,0x68... on consecutive cycles; out_pc 0x60 appears 2 cycles after first grant, then one per cycle.
- btb_hit=1 with target 0x200 at pc 0x64 -> next request 0x200; entry 0x64 has out_pred_taken=1, out_pred_pc=0x200.
- out_ready=0, QDEPTH=4, MAX_OUT=2 -> exactly 4 grants then imem_req=0; queue holds 0x60..0x6C; out_ready=1 resumes issue at 0x70.
- 2 requests outstanding (0x60, 0x64, 3-cycle memory), redirect to 0x403 -> both responses dropped, out_valid stays 0 until 0x400 returns; next out_pc=0x400.
- Redirect coincident with rvalid and an out_ready pop while queue full -> queue empty next cycle, that rdata absent, imem_req=0 that cycle.
- With FETCH_PERF_CNT_EN: previous two scenarios -> perf_squash_cnt=2 (then 3); perf_stall_cnt equals number of blocked cycles counted.

Source files
------------

// File: rtl/stage_fetch_q.sv
// stage_fetch_q: fetch stage owning the PC. Issues instruction-memory requests
// over req/gnt with up to MAX_OUT in flight, steers by BTB prediction, and
// buffers returned words in a QDEPTH-entry queue toward decode (valid/ready).
// An EX redirect flushes the queue and squashes every in-flight response.
// Optional feature: define FETCH_PERF_CNT_EN to add squash/stall perf counters.
module stage_fetch_q #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     QDEPTH   = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            btb_hit,
  input  logic [XLEN-1:0] btb_target,
  output logic [XLEN-1:0] pc_out,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_squash_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int unsigned QAW = $clog2(QDEPTH);
  localparam int unsigned QCW = QAW + 1;
  localparam int unsigned TAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned TCW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW  = ((QCW > TCW) ? QCW : TCW) + 1;

  logic [XLEN-1:0] pc;

  // Fetch queue payload and control.
  logic [XLEN-1:0] q_pc      [QDEPTH];
  logic [XLEN-1:0] q_instr   [QDEPTH];
  logic [XLEN-1:0] q_pred_pc [QDEPTH];
  logic            q_taken   [QDEPTH];
  logic [QAW-1:0]  q_rd, q_wr;
  logic [QCW-1:0]  q_count;

  // Tag FIFO: one entry per granted request, popped by each response in order.
  logic [XLEN-1:0] t_pc    [MAX_OUT];
  logic [XLEN-1:0] t_next  [MAX_OUT];
  logic            t_taken [MAX_OUT];
  logic [TAW-1:0]  t_rd, t_wr;
  logic [TCW-1:0]  outstanding;
  // Responses return in order, so every tag older than a redirect sits at the
  // FIFO head. Counting those stale tags replaces a per-entry live bit: a
  // response is live exactly when stale_cnt is zero.
  logic [TCW-1:0]  stale_cnt;
  logic [TCW-1:0]  live_cnt;
  logic [SW-1:0]   credit_used;

  logic            grant, resp, resp_live, q_push, q_pop;
  logic [XLEN-1:0] next_pc;

  function automatic logic [TAW-1:0] t_inc(input logic [TAW-1:0] p);
    return (p == TAW'(MAX_OUT - 1)) ? '0 : p + TAW'(1);
  endfunction

  assign pc_out    = pc;
  assign imem_addr = pc;

  // Request gating, handshake decode and queue head presentation.
  // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    live_cnt       = outstanding - stale_cnt;
    credit_used    = SW'(q_count) + SW'(live_cnt);
    imem_req       = rst && !redirect_valid && (outstanding < TCW'(MAX_OUT))
                     && (credit_used < SW'(QDEPTH));
    grant          = imem_req && imem_gnt;
    resp           = imem_rvalid && (outstanding != '0);
    resp_live      = resp && !redirect_valid && (stale_cnt == '0);
    next_pc        = btb_hit ? btb_target : pc + XLEN'(4);
    out_valid      = (q_count != '0);
    q_push         = resp_live;
    q_pop          = out_valid && out_ready && !redirect_valid;
    out_pc         = out_valid ? q_pc[q_rd]      : '0;
    out_instr      = out_valid ? q_instr[q_rd]   : '0;
    out_pred_taken = out_valid ? q_taken[q_rd]   : 1'b0;
    out_pred_pc    = out_valid ? q_pred_pc[q_rd] : '0;
  end

  // PC, tag FIFO pointers/counters and queue pointers; redirect has priority.
  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      t_rd        <= '0;
      t_wr        <= '0;
      outstanding <= '0;
      stale_cnt   <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_count     <= '0;
    end else begin
      if (grant) t_wr <= t_inc(t_wr);
      if (resp)  t_rd <= t_inc(t_rd);

      case ({grant, resp})
        2'b10:   outstanding <= outstanding + TCW'(1);
        2'b01:   outstanding <= outstanding - TCW'(1);
        default: outstanding <= outstanding;
      endcase

      if (redirect_valid) begin
        // Every tag still in the FIFO after this cycle's pop becomes stale.
        pc        <= {redirect_pc[XLEN-1:2], 2'b00};
        stale_cnt <= outstanding - (resp ? TCW'(1) : TCW'(0));
        q_rd      <= '0;
        q_wr      <= '0;
        q_count   <= '0;
      end else begin
        if (grant) pc <= next_pc;
        if (resp && (stale_cnt != '0)) stale_cnt <= stale_cnt - TCW'(1);
        if (q_push) q_wr <= q_wr + QAW'(1);
        if (q_pop)  q_rd <= q_rd + QAW'(1);
        case ({q_push, q_pop})
          2'b10:   q_count <= q_count + QCW'(1);
          2'b01:   q_count <= q_count - QCW'(1);
          default: q_count <= q_count;
        endcase
      end
    end
  end

  // Payload storage for the tag FIFO and fetch queue.
  // NOTE: storage arrays are not reset; pointers and counts guard every read, so reset values are never observed.
  always_ff @(posedge clk) begin
    if (grant) begin
      t_pc[t_wr]    <= pc;
      t_next[t_wr]  <= next_pc;
      t_taken[t_wr] <= btb_hit;
    end
    if (q_push) begin
      q_pc[q_wr]      <= t_pc[t_rd];
      q_instr[q_wr]   <= imem_rdata;
      q_pred_pc[q_wr] <= t_next[t_rd];
      q_taken[q_wr]   <= t_taken[t_rd];
    end
  end

  // A response with no request in flight is a memory protocol violation.
  a_rvalid_tracked: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outstanding != '0));

`ifdef FETCH_PERF_CNT_EN
  logic squash_evt, stall_evt;
  assign squash_evt = resp && (redirect_valid || (stale_cnt != '0));
  assign stall_evt  = !redirect_valid && !imem_req;

  // Saturating counters of dropped stale responses and credit/limit stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_squash_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (squash_evt && (perf_squash_cnt != '1)) perf_squash_cnt <= perf_squash_cnt + 32'd1;
      if (stall_evt && (perf_stall_cnt != '1))   perf_stall_cnt  <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_fetch_q.sv
// tb_stage_fetch_q: scoreboard bench for stage_fetch_q. A behavioural memory
// answers granted requests after a configurable latency; expected queue
// entries are pushed when live responses return and popped on decode accepts.
// Perf counter checks are active when FETCH_PERF_CNT_EN is defined.
module tb_stage_fetch_q;

  localparam int          XLEN     = 32;
  localparam int          QDEPTH   = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        btb_hit = 1'b0;
  logic [31:0] btb_target = '0;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic [31:0] out_pred_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_squash_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  stage_fetch_q #(
    .XLEN(XLEN), .QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_hit(btb_hit), .btb_target(btb_target), .pc_out(pc_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_pred_taken(out_pred_taken), .out_pred_pc(out_pred_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_squash_cnt(perf_squash_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        taken;
    logic [31:0] next;
    int          due;
    bit          live;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] next;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] next;
    int          cyc;
  } olog_t;

  int n_checks = 0;
  int n_fails  = 0;

  // Stimulus controls, applied by step() each cycle.
  bit          redir = 0;
  logic [31:0] redir_pc = '0;
  bit          rdy = 1;
  bit          btb_en = 0;
  logic [31:0] btb_pc = '0;
  logic [31:0] btb_tgt = '0;
  bit          gnt_en = 1;
  int          lat = 1;
  int          cyc = 0;

  // Reference model state.
  pend_t       pend[$];
  exp_t        sb[$];
  logic [31:0] exp_pc;
  int          squash_m;
  int          stall_m;
  logic [31:0] grant_log[$];
  int          grant_cyc[$];
  olog_t       out_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, advance models.
  task automatic step();
    bit    rv, req_m, grant;
    int    live_n;
    pend_t p;
    exp_t  e;
    olog_t o;
    logic [31:0] nxt;
    @(negedge clk);
    cyc++;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    out_ready      = rdy;
    btb_hit        = btb_en && (pc_out == btb_pc);
    btb_target     = btb_tgt;
    rv             = (pend.size() != 0) && (pend[0].due <= cyc);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(pend[0].addr) : '0;
    imem_gnt       = gnt_en;
    #1;
    live_n = 0;
    foreach (pend[i]) if (pend[i].live) live_n++;
    req_m = !redir && (pend.size() < MAX_OUT) && ((sb.size() + live_n) < QDEPTH);

    n_checks++;
    if (imem_req !== req_m) begin
      n_fails++;
      $display("FAIL imem_req @%0d: got %b want %b", cyc, imem_req, req_m);
    end
    if (req_m) begin
      n_checks++;
      if (imem_addr !== exp_pc) begin
        n_fails++;
        $display("FAIL imem_addr @%0d: got %h want %h", cyc, imem_addr, exp_pc);
      end
    end

    n_checks++;
    if (out_valid !== (sb.size() != 0)) begin
      n_fails++;
      $display("FAIL out_valid @%0d: got %b want %b", cyc, out_valid, sb.size() != 0);
    end else if (sb.size() != 0) begin
      if (out_pc !== sb[0].pc || out_instr !== sb[0].instr ||
          out_pred_taken !== sb[0].taken || out_pred_pc !== sb[0].next) begin
        n_fails++;
        $display("FAIL out_head @%0d: got pc=%h instr=%h t=%b np=%h want pc=%h instr=%h t=%b np=%h",
                 cyc, out_pc, out_instr, out_pred_taken, out_pred_pc,
                 sb[0].pc, sb[0].instr, sb[0].taken, sb[0].next);
      end
    end

    if (out_valid && out_ready && !redir) begin
      o.pc = out_pc; o.taken = out_pred_taken; o.next = out_pred_pc; o.cyc = cyc;
      out_log.push_back(o);
    end
    if (rdy && !redir && sb.size() != 0) void'(sb.pop_front());
    if (rv) begin
      p = pend.pop_front();
      if (redir || !p.live) squash_m++;
      else begin
        e.pc = p.addr; e.instr = mem_word(p.addr); e.taken = p.taken; e.next = p.next;
        sb.push_back(e);
      end
    end
    if (!redir && !req_m) stall_m++;

    grant = imem_req && gnt_en;
    nxt   = btb_hit ? btb_tgt : exp_pc + 32'd4;
    if (grant) begin
      p.addr = exp_pc; p.taken = btb_hit; p.next = nxt; p.due = cyc + lat; p.live = 1;
      pend.push_back(p);
      grant_log.push_back(imem_addr);
      grant_cyc.push_back(cyc);
    end
    if (redir) begin
      exp_pc = {redir_pc[31:2], 2'b00};
      sb.delete();
      foreach (pend[i]) pend[i].live = 0;
    end else if (grant) begin
      exp_pc = nxt;
    end
  endtask

  // Assert reset (works mid-operation), check cleared outputs, release.
  task automatic test_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; out_ready = 0; btb_hit = 0;
    redir = 0; rdy = 1; btb_en = 0; gnt_en = 1; lat = 1;
    pend.delete(); sb.delete(); grant_log.delete(); grant_cyc.delete(); out_log.delete();
    exp_pc = RESET_PC; squash_m = 0; stall_m = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fails++; $display("FAIL %s_req: got %b want 0", tag, imem_req); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("FAIL %s_valid: got %b want 0", tag, out_valid); end
    n_checks++;
    if (pc_out !== RESET_PC) begin n_fails++; $display("FAIL %s_pc: got %h want %h", tag, pc_out, RESET_PC); end
    n_checks++;
    if (out_pc !== '0 || out_instr !== '0 || out_pred_taken !== 1'b0 || out_pred_pc !== '0) begin
      n_fails++;
      $display("FAIL %s_out: got %h %h %b %h want zeros", tag, out_pc, out_instr, out_pred_taken, out_pred_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_squash_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      n_fails++;
      $display("FAIL %s_perf: got %0d %0d want 0 0", tag, perf_squash_cnt, perf_stall_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    repeat (22) step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant_log.size() <= i || grant_log[i] !== RESET_PC + 32'(4 * i)) begin
        n_fails++;
        $display("FAIL stream_addr%0d: got %h want %h", i,
                 (grant_log.size() > i) ? grant_log[i] : 32'hx, RESET_PC + 32'(4 * i));
      end
    end
    n_checks++;
    if (out_log.size() == 0 || grant_cyc.size() == 0 || out_log[0].cyc - grant_cyc[0] != 2
        || out_log[0].pc !== 32'h60) begin
      n_fails++;
      $display("FAIL stream_latency: got outs=%0d", out_log.size());
    end
    n_checks++;
    if (out_log.size() != 20 || out_log[out_log.size()-1].cyc - out_log[0].cyc != 19) begin
      n_fails++;
      $display("FAIL stream_rate: got %0d pops want 20 consecutive", out_log.size());
    end
  endtask

  task automatic test_btb();
    btb_en = 1; btb_pc = 32'h64; btb_tgt = 32'h200;
    repeat (10) step();
    btb_en = 0;
    n_checks++;
    if (grant_log.size() < 4 || grant_log[1] !== 32'h64 || grant_log[2] !== 32'h200 || grant_log[3] !== 32'h204) begin
      n_fails++;
      $display("FAIL btb_addr: got %0d grants want 64,200,204 sequence", grant_log.size());
    end
    n_checks++;
    if (out_log.size() < 3 || out_log[1].pc !== 32'h64 || out_log[1].taken !== 1'b1 || out_log[1].next !== 32'h200) begin
      n_fails++;
      $display("FAIL btb_entry: got %0d outs want pc=64 taken=1 pred=200", out_log.size());
    end else begin
      n_checks++;
      if (out_log[0].taken !== 1'b0 || out_log[0].next !== 32'h64) begin
        n_fails++;
        $display("FAIL btb_nohit: got t=%b np=%h want t=0 np=64", out_log[0].taken, out_log[0].next);
      end
    end
  endtask

  task automatic test_backpressure();
    rdy = 0;
    repeat (8) step();
    n_checks++;
    if (grant_log.size() != 4) begin
      n_fails++;
      $display("FAIL bp_grants: got %0d want 4", grant_log.size());
    end
    n_checks++;
    if (imem_req !== 1'b0) begin n_fails++; $display("FAIL bp_req: got %b want 0", imem_req); end
    rdy = 1;
    repeat (6) step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_log.size() <= i || out_log[i].pc !== 32'h60 + 32'(4 * i)) begin
        n_fails++;
        $display("FAIL bp_queue%0d: got %h want %h", i,
                 (out_log.size() > i) ? out_log[i].pc : 32'hx, 32'h60 + 32'(4 * i));
      end
    end
    n_checks++;
    if (grant_log.size() < 5 || grant_log[4] !== 32'h70) begin
      n_fails++;
      $display("FAIL bp_resume: got %0d grants want 5th at 70", grant_log.size());
    end
  endtask

  task automatic test_redirect_squash();
    lat = 3; rdy = 1;
    repeat (2) step();
    redir = 1; redir_pc = 32'h403;
    step();
    redir = 0;
    repeat (8) step();
    n_checks++;
    if (grant_log.size() < 3 || grant_log[2] !== 32'h400) begin
      n_fails++;
      $display("FAIL squash_addr: got %0d grants want 3rd at 400", grant_log.size());
    end
    n_checks++;
    if (out_log.size() == 0 || out_log[0].pc !== 32'h400 || grant_cyc.size() < 3
        || out_log[0].cyc - grant_cyc[2] != 4) begin
      n_fails++;
      $display("FAIL squash_first_out: got %0d outs want first 400 at grant+4", out_log.size());
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_squash_cnt !== 32'd2) begin
      n_fails++;
      $display("FAIL squash_cnt: got %0d want 2", perf_squash_cnt);
    end
`endif
  endtask

  task automatic test_redirect_full();
    bit found = 0;
    int base;
    rdy = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (sb.size() == 3 && pend.size() != 0 && pend[0].live && pend[0].due <= cyc + 1) found = 1;
      else step();
    end
    n_checks++;
    if (!found) begin
      n_fails++;
      $display("FAIL full_setup: got timeout want full queue with response due");
    end else begin
      redir = 1; redir_pc = 32'h100; rdy = 1;
      base = out_log.size();
      step();
      redir = 0;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fails++; $display("FAIL full_flush: got %b want 0", out_valid); end
      repeat (12) step();
      n_checks++;
      if (out_log.size() <= base || out_log[base].pc !== 32'h100) begin
        n_fails++;
        $display("FAIL full_next: got %0d new outs want first at 100", out_log.size() - base);
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if (perf_squash_cnt !== 32'(squash_m)) begin
        n_fails++;
        $display("FAIL full_squash_cnt: got %0d want %0d", perf_squash_cnt, squash_m);
      end
      n_checks++;
      if (perf_stall_cnt !== 32'(stall_m)) begin
        n_fails++;
        $display("FAIL full_stall_cnt: got %0d want %0d", perf_stall_cnt, stall_m);
      end
`endif
    end
  endtask

  task automatic test_wrap();
    redir = 1; redir_pc = 32'hFFFF_FFFF;
    step();
    redir = 0;
    repeat (6) step();
    n_checks++;
    if (grant_log.size() < 2 || grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0) begin
      n_fails++;
      $display("FAIL wrap_addr: got %0d grants want FFFFFFFC then 0", grant_log.size());
    end
    n_checks++;
    if (out_log.size() == 0 || out_log[0].pc !== 32'hFFFF_FFFC || out_log[0].next !== 32'h0) begin
      n_fails++;
      $display("FAIL wrap_pred: got %0d outs want pc=FFFFFFFC pred=0", out_log.size());
    end
  endtask

  task automatic test_restart();
    repeat (3) step();
    n_checks++;
    if (grant_log.size() == 0 || grant_log[0] !== RESET_PC) begin
      n_fails++;
      $display("FAIL restart_addr: got %0d grants want first at %h", grant_log.size(), RESET_PC);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset("rst0");
    test_stream();
    test_reset("rst1");
    test_btb();
    test_reset("rst2");
    test_backpressure();
    test_reset("rst3");
    test_redirect_squash();
    test_redirect_full();
    test_reset("rst4");
    test_wrap();
    repeat (3) step();
    test_reset("rst_mid");
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
